// File: rtl/dm_line_cache.sv
// dm_line_cache: direct-mapped, write-through, read-allocate line cache.
// Optional flush input enabled by defining DM_LINE_CACHE_FLUSH_EN.
module dm_line_cache #(
   parameter int NUM_SETS   = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
`ifdef DM_LINE_CACHE_FLUSH_EN
   input  logic        flush_i,
`endif
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wdata_i,
   input  logic        core_we_i,
   input  logic        core_req_i,
   input  logic [3:0]  core_be_i,
   output logic [31:0] core_rdata_o,
   output logic        core_gnt_o,
   output logic        core_rvalid_o,
   output logic        core_error_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        mem_we_o,
   output logic        mem_req_o,
   output logic [3:0]  mem_be_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic        mem_error_i
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = 30 - OFF_W - IDX_W;
   localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
   localparam int DEPTH = NUM_SETS * LINE_WORDS;
   localparam int AW    = $clog2(DEPTH);

   typedef enum logic [2:0] {
      IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, WT_REQ, WT_WAIT, RESP
   } state_e;

   state_e              state_q, state_d;
   logic [31:2]         addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                we_q, we_d;
   logic [3:0]          be_q, be_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [NUM_SETS-1:0] valid_q, valid_d;

   logic [TAG_W-1:0]    tag_q [NUM_SETS];
   logic [31:0]         data_q [DEPTH];

   logic [31:0]         addr_w;
   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    tag;
   logic [CNT_W-1:0]    word;
   logic [AW-1:0]       rd_ptr, wr_ptr, data_ptr;
   logic [31:0]         stored, merged, data_wval;
   logic [31:0]         line_base, refill_addr;
   logic                hit, gnt, data_we, tag_we;
   logic                unused_addr;

   assign unused_addr = ^core_addr_i[1:0];

   assign addr_w      = {addr_q, 2'b00};
   assign idx         = IDX_W'(addr_w >> (OFF_W + 2));
   assign tag         = TAG_W'(addr_w >> (OFF_W + IDX_W + 2));
   assign word        = CNT_W'((addr_w >> 2) & 32'(LINE_WORDS - 1));
   assign rd_ptr      = AW'((32'(idx) << OFF_W) | 32'(word));
   assign wr_ptr      = AW'((32'(idx) << OFF_W) | 32'(cnt_q));
   assign stored      = data_q[rd_ptr];
   assign hit         = valid_q[idx] && (tag_q[idx] == tag);
   assign line_base   = addr_w & ~32'((LINE_WORDS * 4) - 1);
   assign refill_addr = line_base | (32'(cnt_q) << 2);

   assign core_gnt_o   = gnt & ~reset;
   assign core_rdata_o = rdata_q;
   assign core_error_o = core_rvalid_o & err_q;

   // Byte-enable merge of the registered write into the stored word
   always_comb begin
      merged = stored;
      for (int b = 0; b < 4; b++) begin
         if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
      end
   end

   // Next-state, bus outputs and storage update controls
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      we_d          = we_q;
      be_d          = be_q;
      cnt_d         = cnt_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
      valid_d       = valid_q;
      gnt           = 1'b0;
      core_rvalid_o = 1'b0;
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      mem_be_o      = 4'h0;
      mem_addr_o    = 32'h0;
      mem_wdata_o   = 32'h0;
      data_we       = 1'b0;
      data_ptr      = rd_ptr;
      data_wval     = merged;
      tag_we        = 1'b0;
      unique case (state_q)
         IDLE: begin
`ifdef DM_LINE_CACHE_FLUSH_EN
            if (flush_i) begin
               valid_d = '0;
            end else
`endif
            if (core_req_i) begin
               gnt     = 1'b1;
               addr_d  = core_addr_i[31:2];
               wdata_d = core_wdata_i;
               we_d    = core_we_i;
               be_d    = core_be_i;
               err_d   = 1'b0;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (we_q) begin
               if (hit) data_we = 1'b1;
               state_d = WT_REQ;
            end else if (hit) begin
               rdata_d = stored;
               state_d = RESP;
            end else begin
               valid_d[idx] = 1'b0;
               cnt_d        = '0;
               state_d      = REFILL_REQ;
            end
         end
         REFILL_REQ: begin
            mem_req_o  = 1'b1;
            mem_be_o   = 4'hF;
            mem_addr_o = refill_addr;
            if (mem_gnt_i) state_d = REFILL_WAIT;
         end
         REFILL_WAIT: begin
            if (mem_rvalid_i) begin
               data_we   = 1'b1;
               data_ptr  = wr_ptr;
               data_wval = mem_rdata_i;
               if (cnt_q == word) rdata_d = mem_rdata_i;
               if (mem_error_i) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
                  tag_we       = 1'b1;
                  valid_d[idx] = 1'b1;
                  state_d      = RESP;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = REFILL_REQ;
               end
            end
         end
         WT_REQ: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_be_o    = be_q;
            mem_wdata_o = wdata_q;
            mem_addr_o  = addr_w;
            if (mem_gnt_i) state_d = WT_WAIT;
         end
         WT_WAIT: begin
            if (mem_rvalid_i) begin
               err_d   = mem_error_i;
               state_d = RESP;
            end
         end
         RESP: begin
            core_rvalid_o = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state, request capture and valid bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         be_q    <= be_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   // Tag and data arrays; contents are only meaningful under a valid bit
   always_ff @(posedge clk) begin
      if (data_we) data_q[data_ptr] <= data_wval;
      if (tag_we) tag_q[idx] <= tag;
   end

endmodule

// File: tb/tb_dm_line_cache.sv
// tb_dm_line_cache: directed vectors, corner sequences and a randomized
// run against a line-level cache model for dm_line_cache (16 sets x 4 words).
module tb_dm_line_cache;

   logic        clk = 1'b0;
   logic        reset;
`ifdef DM_LINE_CACHE_FLUSH_EN
   logic        flush_i;
`endif
   logic [31:0] core_addr_i, core_wdata_i;
   logic        core_we_i, core_req_i;
   logic [3:0]  core_be_i;
   logic [31:0] core_rdata_o;
   logic        core_gnt_o, core_rvalid_o, core_error_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_we_o, mem_req_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_rdata_i;
   logic        mem_gnt_i, mem_rvalid_i, mem_error_i;

   always #5 clk = ~clk;

   dm_line_cache #(.NUM_SETS(16), .LINE_WORDS(4)) dut (
      .clk           (clk),
      .reset         (reset),
`ifdef DM_LINE_CACHE_FLUSH_EN
      .flush_i       (flush_i),
`endif
      .core_addr_i   (core_addr_i),
      .core_wdata_i  (core_wdata_i),
      .core_we_i     (core_we_i),
      .core_req_i    (core_req_i),
      .core_be_i     (core_be_i),
      .core_rdata_o  (core_rdata_o),
      .core_gnt_o    (core_gnt_o),
      .core_rvalid_o (core_rvalid_o),
      .core_error_o  (core_error_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_we_o      (mem_we_o),
      .mem_req_o     (mem_req_o),
      .mem_be_o      (mem_be_o),
      .mem_rdata_i   (mem_rdata_i),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_error_i   (mem_error_i)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Bus-side memory: unwritten words read as C0DE_xxxx (low address half)
   logic [31:0] mem [int unsigned];

   function automatic logic [31:0] memrd(input logic [31:0] a);
      if (mem.exists(a >> 2)) return mem[a >> 2];
      return 32'hC0DE_0000 | (a & 32'h0000_FFFC);
   endfunction

   int          stall = 0;
   int          err_at = 0;
   bit          err_wr = 0;
   bit          pend = 0;
   logic [31:0] pend_addr;
   bit          pend_we, pend_err;
   int          rd_cnt, wr_cnt, proto_err = 0;
   logic [31:0] rd_log [$];
   logic [31:0] req_log [$];
   logic [31:0] wr_addr_l, wr_data_l, mw;
   logic [3:0]  wr_be_l;

   always @(negedge clk) begin
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_error_i  = 1'b0;
      mem_rdata_i  = 32'h0;
      if (reset) begin
         pend = 0;
      end else begin
         if (pend) begin
            mem_rvalid_i = 1'b1;
            mem_error_i  = pend_err;
            mem_rdata_i  = pend_we ? 32'h0 : memrd(pend_addr);
            pend = 0;
         end
         if (mem_req_o) begin
            req_log.push_back(mem_addr_o);
            if (stall > 0) begin
               stall--;
            end else begin
               mem_gnt_i = 1'b1;
               pend      = 1;
               pend_addr = mem_addr_o;
               pend_we   = mem_we_o;
               pend_err  = 0;
               if (mem_we_o) begin
                  wr_cnt++;
                  wr_addr_l = mem_addr_o;
                  wr_data_l = mem_wdata_o;
                  wr_be_l   = mem_be_o;
                  mw = memrd(mem_addr_o);
                  for (int b = 0; b < 4; b++)
                     if (mem_be_o[b]) mw[8*b +: 8] = mem_wdata_o[8*b +: 8];
                  mem[mem_addr_o >> 2] = mw;
                  pend_err = err_wr;
               end else begin
                  rd_cnt++;
                  rd_log.push_back(mem_addr_o);
                  if (rd_cnt == err_at) pend_err = 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      #2;
      if (!reset) begin
         if (core_gnt_o && core_rvalid_o) proto_err++;
         if (mem_req_o && mem_rvalid_i) proto_err++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   task automatic access(input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] rdata, output bit err,
                         output int lat);
      int w;
      rd_cnt = 0;
      wr_cnt = 0;
      rd_log.delete();
      req_log.delete();
      rdata = 32'h0;
      err   = 0;
      lat   = 0;
      @(negedge clk);
      core_req_i   = 1'b1;
      core_we_i    = we;
      core_addr_i  = addr;
      core_wdata_i = wdata;
      core_be_i    = be;
      #1;
      w = 0;
      while (!core_gnt_o && w < 50) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (!core_gnt_o) begin
         check("gnt_timeout", 32'(core_gnt_o), 32'h1);
         core_req_i = 1'b0;
         return;
      end
      @(negedge clk);
      core_req_i = 1'b0;
      lat = 1;
      #1;
      while (!core_rvalid_o && lat < 200) begin
         @(negedge clk);
         #1;
         lat++;
      end
      if (!core_rvalid_o) begin
         check("rvalid_timeout", 32'(core_rvalid_o), 32'h1);
         return;
      end
      rdata = core_rdata_o;
      err   = core_error_o;
   endtask

   task automatic check_refill(input string name, input logic [31:0] addr);
      check({name, "_nreads"}, 32'(rd_log.size()), 32'd4);
      if (rd_log.size() == 4)
         for (int k = 0; k < 4; k++)
            check({name, "_raddr"}, rd_log[k], (addr & ~32'hF) + 32'(4 * k));
   endtask

   function automatic logic [31:0] outs_or();
      return core_rdata_o | mem_addr_o | mem_wdata_o |
             {23'h0, core_gnt_o, core_rvalid_o, core_error_o,
              mem_req_o, mem_we_o, mem_be_o};
   endfunction

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      int          exp_rd;
      int          exp_wr;
      int          exp_lat;
   } vec_t;

   vec_t        vt [9];
   logic [31:0] rd;
   bit          er;
   int          lt, w;

   // Line-level reference model for the random phase
   bit          mv [16];
   logic [31:0] mtag [16];
   logic [31:0] md [16][4];

   initial begin
      vt[0] = '{0, 32'h104, 32'h0,        4'hF, 32'h1122_3344, 4, 0, 10};
      vt[1] = '{0, 32'h108, 32'h0,        4'hF, 32'hC0DE_0108, 0, 0, 2};
      vt[2] = '{1, 32'h104, 32'hAABBCCDD, 4'h2, 32'h0,         0, 1, 4};
      vt[3] = '{0, 32'h104, 32'h0,        4'hF, 32'h1122_CC44, 0, 0, 2};
      vt[4] = '{1, 32'h300, 32'h12345678, 4'hF, 32'h0,         0, 1, 4};
      vt[5] = '{0, 32'h300, 32'h0,        4'hF, 32'h1234_5678, 4, 0, 10};
      vt[6] = '{0, 32'h104, 32'h0,        4'hF, 32'h1122_CC44, 4, 0, 10};
      vt[7] = '{0, 32'h504, 32'h0,        4'hF, 32'hC0DE_0504, 4, 0, 10};
      vt[8] = '{0, 32'h104, 32'h0,        4'hF, 32'h1122_CC44, 4, 0, 10};

      mem[32'h104 >> 2] = 32'h1122_3344;
      reset        = 1'b1;
`ifdef DM_LINE_CACHE_FLUSH_EN
      flush_i      = 1'b0;
`endif
      core_req_i   = 1'b1;
      core_we_i    = 1'b0;
      core_addr_i  = 32'h0;
      core_wdata_i = 32'h0;
      core_be_i    = 4'h0;
      #1;
      check("reset_outputs", outs_or(), 32'h0);
      core_req_i = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         access(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd, er, lt);
         if (!vt[i].we) check($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
         check($sformatf("v%0d_err", i), 32'(er), 32'h0);
         check($sformatf("v%0d_nrd", i), 32'(rd_cnt), 32'(vt[i].exp_rd));
         check($sformatf("v%0d_nwr", i), 32'(wr_cnt), 32'(vt[i].exp_wr));
         check($sformatf("v%0d_lat", i), 32'(lt), 32'(vt[i].exp_lat));
         if (vt[i].exp_rd == 4) check_refill($sformatf("v%0d", i), vt[i].addr);
         if (vt[i].we) begin
            check($sformatf("v%0d_waddr", i), wr_addr_l, vt[i].addr & ~32'h3);
            check($sformatf("v%0d_wdata", i), wr_data_l, vt[i].wdata);
            check($sformatf("v%0d_wbe", i), 32'(wr_be_l), 32'(vt[i].be));
         end
      end

      // Grant held off for three cycles on the first refill word
      stall = 3;
      access(0, 32'h704, 32'h0, 4'hF, rd, er, lt);
      check("stall_rdata", rd, 32'hC0DE_0704);
      check("stall_nreq", 32'(req_log.size()), 32'd7);
      if (req_log.size() == 7)
         for (int k = 0; k < 4; k++) check("stall_addr", req_log[k], 32'h700);
      check_refill("stall", 32'h704);

      // Bus error on the third refill word
      err_at = 3;
      access(0, 32'h904, 32'h0, 4'hF, rd, er, lt);
      err_at = 0;
      check("rerr_err", 32'(er), 32'h1);
      check("rerr_nrd", 32'(rd_cnt), 32'd3);
      access(0, 32'h904, 32'h0, 4'hF, rd, er, lt);
      check("rerr_again_err", 32'(er), 32'h0);
      check("rerr_again_nrd", 32'(rd_cnt), 32'd4);
      check("rerr_again_rdata", rd, 32'hC0DE_0904);

      // Bus error on a write-through
      err_wr = 1;
      access(1, 32'h904, 32'hDEADBEEF, 4'hF, rd, er, lt);
      err_wr = 0;
      check("werr_err", 32'(er), 32'h1);
      access(0, 32'h904, 32'h0, 4'hF, rd, er, lt);
      check("werr_hit_nrd", 32'(rd_cnt), 32'd0);
      check("werr_hit_rdata", rd, 32'hDEADBEEF);

`ifdef DM_LINE_CACHE_FLUSH_EN
      access(0, 32'h104, 32'h0, 4'hF, rd, er, lt);
      access(0, 32'h104, 32'h0, 4'hF, rd, er, lt);
      check("flush_pre_nrd", 32'(rd_cnt), 32'd0);
      @(negedge clk);
      flush_i     = 1'b1;
      core_req_i  = 1'b1;
      core_we_i   = 1'b0;
      core_addr_i = 32'h104;
      #1;
      check("flush_gnt", 32'(core_gnt_o), 32'h0);
      @(negedge clk);
      flush_i    = 1'b0;
      core_req_i = 1'b0;
      access(0, 32'h104, 32'h0, 4'hF, rd, er, lt);
      check("flush_post_nrd", 32'(rd_cnt), 32'd4);
      check("flush_post_rdata", rd, 32'h1122_CC44);
`endif

      // Reset in the middle of a refill
      access(0, 32'h104, 32'h0, 4'hF, rd, er, lt);
      rd_cnt = 0;
      @(negedge clk);
      core_req_i  = 1'b1;
      core_we_i   = 1'b0;
      core_addr_i = 32'hB14;
      @(negedge clk);
      core_req_i = 1'b0;
      w = 0;
      while (rd_cnt < 2 && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("rst_mid_started", 32'(rd_cnt >= 2), 32'h1);
      core_req_i = 1'b1;
      reset      = 1'b1;
      #1;
      check("rst_mid_outputs", outs_or(), 32'h0);
      @(negedge clk);
      reset      = 1'b0;
      core_req_i = 1'b0;
      pend       = 0;
      access(0, 32'h104, 32'h0, 4'hF, rd, er, lt);
      check("rst_mid_nrd", 32'(rd_cnt), 32'd4);
      check("rst_mid_rdata", rd, 32'h1122_CC44);

      // Randomized accesses against the line-level model
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int s = 0; s < 16; s++) mv[s] = 0;
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a, wd, ex;
         logic [3:0]  b;
         bit          rwe, h;
         int          ix, wi;
         a   = (32'($urandom_range(0, 3)) << 8) |
               (32'($urandom_range(0, 15)) << 4) |
               (32'($urandom_range(0, 3)) << 2);
         rwe = ($urandom_range(0, 2) == 0);
         wd  = $urandom;
         b   = 4'($urandom_range(0, 15));
         ix  = int'((a >> 4) & 32'hF);
         wi  = int'((a >> 2) & 32'h3);
         h   = mv[ix] && (mtag[ix] == (a >> 8));
         ex  = h ? md[ix][wi] : memrd(a);
         stall = $urandom_range(0, 2);
         access(rwe, a, wd, b, rd, er, lt);
         stall = 0;
         check("rnd_err", 32'(er), 32'h0);
         check("rnd_nwr", 32'(wr_cnt), rwe ? 32'd1 : 32'd0);
         if (rwe) begin
            check("rnd_waddr", wr_addr_l, a);
            check("rnd_nrd_w", 32'(rd_cnt), 32'd0);
            if (h)
               for (int k = 0; k < 4; k++)
                  if (b[k]) md[ix][wi][8*k +: 8] = wd[8*k +: 8];
         end else begin
            check("rnd_rdata", rd, ex);
            check("rnd_nrd", 32'(rd_cnt), h ? 32'd0 : 32'd4);
            if (h) check("rnd_hit_lat", 32'(lt), 32'd2);
            if (!h) begin
               mv[ix]   = 1;
               mtag[ix] = a >> 8;
               for (int k = 0; k < 4; k++)
                  md[ix][k] = memrd((a & ~32'hF) + 32'(4 * k));
            end
         end
      end

      check("protocol", 32'(proto_err), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dm_line_cache.md
Name: dm_line_cache

Overview:
- Parametrised direct-mapped, write-through, read-allocate cache between the PULPino core data/instruction port and the memory bus.
- Supersedes the single-word cache:
  - multi-word lines refilled by burst of single-word transactions;
  - full req/gnt/rvalid handshake on both sides;
  - byte-enable-correct writes;
  - error propagation.
- One outstanding core request at a time.

Parameters:
- NUM_SETS, 64, number of lines; power of 2, >= 2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, >= 1.
- Derived widths:
  - OFF_W = log2(LINE_WORDS)
  - IDX_W = log2(NUM_SETS)
  - TAG_W = 30 - OFF_W - IDX_W

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- core_addr_i  in  32  byte address; bits [1:0] ignored
- core_wdata_i  in  32  write data
- core_we_i  in  1  1 = write
- core_req_i  in  1  request
- core_be_i  in  4  byte enables
- core_rdata_o  out  32  read data; valid only with core_rvalid_o
- core_gnt_o  out  1  request accepted this cycle
- core_rvalid_o  out  1  one-cycle response pulse
- core_error_o  out  1  bus error; qualified by core_rvalid_o
- mem_addr_o  out  32  memory word address
- mem_wdata_o  out  32  memory write data
- mem_we_o  out  1  memory write
- mem_req_o  out  1  memory request
- mem_be_o  out  4  memory byte enables
- mem_rdata_i  in  32  memory read data
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response
- mem_error_i  in  1  memory error; qualified by mem_rvalid_i

Behaviour:
- Address split: tag = addr[31:OFF_W+IDX_W+2], index = addr[OFF_W+IDX_W+1:OFF_W+2], word = addr[OFF_W+1:2].
- Storage per set: tag, valid bit, LINE_WORDS data words.
- Reset (async):
  - all valid bits cleared; FSM to IDLE;
  - all outputs 0 (core_gnt_o, core_rvalid_o, core_error_o, mem_req_o, mem_we_o = 0; data and address buses 0).
  - Reset mid-refill or mid-write aborts the transaction; no partial line becomes valid.
- States: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, WT_REQ, WT_WAIT, RESP.
- IDLE:
  - core_gnt_o = core_req_i (combinational).
  - On grant, register addr, wdata, we, be -> LOOKUP.
  - core_gnt_o is 0 in every other state.
- LOOKUP: hit = valid && tag match.
  - Read hit -> RESP, data = stored word.
  - Write hit: merge core bytes where be=1 into stored word this cycle -> WT_REQ.
  - Write miss: no allocate -> WT_REQ.
  - Read miss: clear valid of the indexed set, word counter = 0 -> REFILL_REQ.
- REFILL_REQ:
  - mem_req_o = 1, mem_we_o = 0, mem_be_o = 4'hF;
  - mem_addr_o = {tag, index, counter, 2'b00}.
  - Request and address held stable until mem_gnt_i -> REFILL_WAIT.
- REFILL_WAIT:
  - on mem_rvalid_i, store mem_rdata_i at counter;
  - if mem_error_i -> RESP with error, line stays invalid;
  - else if counter = LINE_WORDS-1: set tag, set valid -> RESP (data = requested word);
  - else counter + 1 -> REFILL_REQ.
- WT_REQ:
  - mem_req_o = 1, mem_we_o = 1;
  - mem_be_o = registered be, mem_wdata_o = registered wdata;
  - mem_addr_o = registered addr with [1:0] = 0.
  - Hold until mem_gnt_i -> WT_WAIT.
- WT_WAIT: on mem_rvalid_i -> RESP; core_error_o = mem_error_i; cache contents untouched by the error.
- RESP: core_rvalid_o = 1 for exactly one cycle -> IDLE.
- Latency:
  - read hit: rvalid 2 cycles after gnt;
  - miss: 2 + LINE_WORDS × (memory round trip).
- Refill is in ascending word order (word 0 first), not critical-word-first.
- Single memory transaction outstanding; mem_req_o is deasserted in cycles after grant.
- gnt and rvalid never high in the same cycle.

Optional Feature:
- Macro: DM_LINE_CACHE_FLUSH_EN.
- When defined, adds input flush_i (1 bit).
  - flush_i is sampled only in IDLE and takes priority over core_req_i: gnt = 0 that cycle.
  - All valid bits clear on the next edge.
  - flush_i asserted in other states is ignored; the requester holds it until IDLE.
- When undefined: port absent; lines are invalidated only by reset or miss replacement.

Test Plan (NUM_SETS=16, LINE_WORDS=4):
- Cold read miss 0x0000_0104 -> four mem reads at 0x100, 0x104, 0x108, 0x10C; then rvalid with the 0x104 data. A following read of 0x108 produces no mem_req and rvalid 2 cycles after gnt.
- Write hit to 0x104 holding 0x11223344, be=4'b0010, wdata 0xAABBCCDD:
  - mem write at 0x104, be 0010, wdata 0xAABBCCDD;
  - a re-read returns 0x1122CC44 without mem access.
- Write miss to 0x300 -> one mem write, no refill; a subsequent read of 0x300 misses.
- Conflict: read 0x104 then 0x504 (same index 0) -> second access refills 0x500–0x50C; re-read of 0x104 misses again.
- mem_gnt_i low for 3 cycles during refill -> mem_req_o and mem_addr_o stable throughout.
- mem_error_i with rvalid on the 3rd refill word -> rvalid with core_error_o = 1; a re-read of the same address misses.
- Flush (macro defined) after filling 0x104 -> the next read of 0x104 misses.
- Reset asserted mid-refill -> all outputs 0 immediately; a re-read of 0x104 misses.
